// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Walks the sequential PC, keeps at most one instruction-memory request in
// flight, and pushes each returned {pc, instr} pair into the instruction FIFO.
// A backend redirect restarts fetch at a new PC. If the redirect arrives while
// a response is still owed, that response is squashed in the DROP state.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [XLEN-1:0]   imem_resp_data,
    input  logic              fifo_full,
    output logic              fifo_write_en,
    output logic [2*XLEN-1:0] fifo_write_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [31:0]       fetch_count
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_PUSH = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t          state_reg,       state_next;
    logic [XLEN-1:0] pc_reg,          pc_next;
    logic [XLEN-1:0] hold_instr_reg,  hold_instr_next;
    logic [31:0]     fetch_count_reg, fetch_count_next;

    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_plus4;
    logic            unused_redirect_low;

    // The low two redirect bits are dropped so every fetch stays word aligned.
    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_low = ^redirect_pc[1:0];
    assign pc_plus4            = pc_reg + {{(XLEN-3){1'b0}}, 3'b100};

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            pc_reg          <= RESET_PC;
            hold_instr_reg  <= '0;
            fetch_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            hold_instr_reg  <= hold_instr_next;
            fetch_count_reg <= fetch_count_next;
        end
    end

    // Next-state logic; a redirect overrides every other event.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        hold_instr_next  = hold_instr_reg;
        fetch_count_next = fetch_count_reg;
        if (redirect_valid) begin
            pc_next = redirect_target;
            case (state_reg)
                ST_IDLE: state_next = ST_REQ;
                // An accepted old-PC request still owes a response: squash it.
                ST_REQ:  state_next = imem_req_ready  ? ST_DROP : ST_REQ;
                ST_WAIT: state_next = imem_resp_valid ? ST_REQ  : ST_DROP;
                ST_PUSH: state_next = ST_REQ;
                ST_DROP: state_next = imem_resp_valid ? ST_REQ  : ST_DROP;
                default: state_next = ST_IDLE;
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_REQ;
                ST_REQ: begin
                    if (imem_req_ready) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        state_next      = ST_PUSH;
                        hold_instr_next = imem_resp_data;
                    end
                end
                ST_PUSH: begin
                    // Full is re-sampled every cycle; data is held until it drops.
                    if (!fifo_full) begin
                        state_next       = ST_REQ;
                        pc_next          = pc_plus4;
                        fetch_count_next = fetch_count_reg + 32'd1;
                    end
                end
                ST_DROP: begin
                    if (imem_resp_valid) begin
                        state_next = ST_REQ;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode: Moore outputs from state and registers, push strobe is Mealy.
    always_comb begin
        imem_req_valid  = (state_reg == ST_REQ);
        imem_req_addr   = pc_reg;
        fifo_write_data = {pc_reg, hold_instr_reg};
        fifo_write_en   = (state_reg == ST_PUSH) && !fifo_full && !redirect_valid;
        fetch_count     = fetch_count_reg;
    end

    // A response is only legal while one is owed (WAIT or DROP).
    resp_only_when_outstanding: assert property (
        @(posedge clk) disable iff (reset)
        imem_resp_valid |-> (state_reg == ST_WAIT || state_reg == ST_DROP)
    );

endmodule
